ili9341_spi_receiver: RTL

Display-side decoder for the 4-wire ILI9341 SPI stream our controller emits (spi_sck, spi_mosi, spi_cs, spi_dc). It oversamples the bus on the system clock, reassembles bytes, and decodes CASET/PASET/RAMWR. It outputs per-pixel writes with (x,y) coordinates and 16-bit RGB565 data.
It serves as the in-fabric display model for self-checking benches and as a mirror tap feeding a secondary framebuffer.

---
 rtl/ili9341_spi_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ili9341_spi_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ili9341_spi_receiver
//  Purpose  : Display-side decoder for a 4-wire ILI9341 SPI stream. The bus is
//             oversampled on clk, bytes are reassembled, and the
//             CASET / PASET / RAMWR commands are decoded into per-pixel writes
//             carrying (x, y) coordinates and RGB565 data.
//  Ports    : clk         system clock (>= 4x spi_sck)
//             rst         synchronous reset, active-low
//             spi_sck     SPI clock, mode 0, asynchronous to clk
//             spi_mosi    SPI data, MSB first
//             spi_cs      chip select, active-low
//             spi_dc      0 = command byte, 1 = data byte
//             cmd_valid   one-cycle pulse per completed command byte
//             cmd_byte    last command byte, held until the next command
//             pix_valid   one-cycle pulse per completed pixel
//             pix_x/pix_y pixel coordinates, valid with pix_valid
//             pix_data    RGB565 pixel value
//             frame_done  pulse with the pixel that closes the window
//             pix_count   (ILI_RX_STATS_EN only) pixels since reset / RAMWR
//             frame_count (ILI_RX_STATS_EN only) frames since reset / RAMWR
//  Options  : define ILI_RX_STATS_EN to add the pix_count / frame_count ports.
//  Revision : 1.0 - initial release
// ============================================================================
module ili9341_spi_receiver #(
    parameter int H_RES   = 240,
    parameter int V_RES   = 320,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_cs,
    input  logic               spi_dc,
    output logic               cmd_valid,
    output logic [7:0]         cmd_byte,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data,
    output logic               frame_done
`ifdef ILI_RX_STATS_EN
    ,
    output logic [31:0]        pix_count,
    output logic [15:0]        frame_count
`endif
);

    localparam logic [COORD_W-1:0] c_xe_rst = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] c_ye_rst = COORD_W'(V_RES - 1);
    localparam logic [COORD_W-1:0] c_one    = COORD_W'(1);

    localparam logic [7:0] c_cmd_caset = 8'h2A;
    localparam logic [7:0] c_cmd_paset = 8'h2B;
    localparam logic [7:0] c_cmd_ramwr = 8'h2C;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CASET = 3'd1;
    localparam logic [2:0] S_PASET = 3'd2;
    localparam logic [2:0] S_RAMWR = 3'd3;
    localparam logic [2:0] S_OTHER = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizers (two flops each) plus a delayed sck for edge
    // detection.
    // ------------------------------------------------------------------
    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_mosi_meta, r_mosi_sync;
    logic r_cs_meta, r_cs_sync;
    logic r_dc_meta, r_dc_sync;
    logic w_sck_rise;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_dc_meta   <= 1'b0;
            r_dc_sync   <= 1'b0;
        end else begin
            r_sck_meta  <= spi_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_cs_meta   <= spi_cs;
            r_cs_sync   <= r_cs_meta;
            r_dc_meta   <= spi_dc;
            r_dc_sync   <= r_dc_meta;
        end
    end

    assign w_sck_rise = r_sck_sync & ~r_sck_prev;

    // ------------------------------------------------------------------
    // Byte assembly. A completed byte is strobed once, then passed through
    // one more register stage so that the decoded outputs land exactly four
    // clk cycles after the raw sck is first seen high.
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_byte_stb;
    logic [7:0] r_byte;
    logic       r_byte_dc;
    logic       r_stb_q;
    logic [7:0] r_byte_q;
    logic       r_dc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_byte_stb <= 1'b0;
            r_byte     <= 8'd0;
            r_byte_dc  <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            if (r_cs_sync) begin
                // Deselect drops any partial byte; stale shift bits are
                // overwritten by the next eight edges.
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_shift <= {r_shift[5:0], r_mosi_sync};
                if (r_bit_cnt == 3'd7) begin
                    r_byte_stb <= 1'b1;
                    r_byte     <= {r_shift, r_mosi_sync};
                    r_byte_dc  <= r_dc_sync;
                    r_bit_cnt  <= 3'd0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stb_q  <= 1'b0;
            r_byte_q <= 8'd0;
            r_dc_q   <= 1'b0;
        end else begin
            r_stb_q  <= r_byte_stb;
            r_byte_q <= r_byte;
            r_dc_q   <= r_byte_dc;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_is_cmd;
    logic       w_is_data;

    assign w_is_cmd  = r_stb_q & ~r_dc_q;
    assign w_is_data = r_stb_q &  r_dc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_is_cmd) begin
            case (r_byte_q)
                c_cmd_caset: w_state_nxt = S_CASET;
                c_cmd_paset: w_state_nxt = S_PASET;
                c_cmd_ramwr: w_state_nxt = S_RAMWR;
                default:     w_state_nxt = S_OTHER;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window, write pointer and output datapath
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye;
    logic [COORD_W-1:0] r_x, r_y;
    logic [2:0]         r_param_cnt;
    logic [15:0]        r_param_start;
    logic [7:0]         r_param_end_hi;
    logic [7:0]         r_hi;
    logic               r_have_hi;
    logic               w_pix_fire;
    logic               w_frame_fire;
    logic [15:0]        w_param_end;
    logic [COORD_W-1:0] w_new_start;
    logic [COORD_W-1:0] w_new_end;

    assign w_pix_fire   = w_is_data & (r_state == S_RAMWR) & r_have_hi;
    assign w_frame_fire = w_pix_fire & (r_x == r_xe) & (r_y == r_ye);
    assign w_param_end  = {r_param_end_hi, r_byte_q};
    assign w_new_start  = r_param_start[COORD_W-1:0];
    assign w_new_end    = w_param_end[COORD_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_valid      <= 1'b0;
            cmd_byte       <= 8'd0;
            pix_valid      <= 1'b0;
            pix_x          <= '0;
            pix_y          <= '0;
            pix_data       <= 16'd0;
            frame_done     <= 1'b0;
            r_xs           <= '0;
            r_xe           <= c_xe_rst;
            r_ys           <= '0;
            r_ye           <= c_ye_rst;
            r_x            <= '0;
            r_y            <= '0;
            r_param_cnt    <= 3'd0;
            r_param_start  <= 16'd0;
            r_param_end_hi <= 8'd0;
            r_hi           <= 8'd0;
            r_have_hi      <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;

            // Deselect discards a half-received pixel. A byte strobe in the
            // same cycle still belongs to the selected transfer, so the
            // assignments below take precedence.
            if (r_cs_sync) begin
                r_have_hi <= 1'b0;
            end

            if (w_is_cmd) begin
                cmd_valid   <= 1'b1;
                cmd_byte    <= r_byte_q;
                r_param_cnt <= 3'd0;
                if (r_byte_q == c_cmd_ramwr) begin
                    r_x       <= r_xs;
                    r_y       <= r_ys;
                    r_have_hi <= 1'b0;
                end
            end else if (w_is_data) begin
                case (r_state)
                    S_CASET, S_PASET: begin
                        // Parameter count saturates at 4 so extra bytes
                        // are ignored.
                        if (r_param_cnt != 3'd4) begin
                            r_param_cnt <= r_param_cnt + 3'd1;
                            case (r_param_cnt)
                                3'd0: r_param_start[15:8] <= r_byte_q;
                                3'd1: r_param_start[7:0]  <= r_byte_q;
                                3'd2: r_param_end_hi      <= r_byte_q;
                                default: begin
                                    if (r_state == S_CASET) begin
                                        r_xs <= w_new_start;
                                        r_xe <= w_new_end;
                                    end else begin
                                        r_ys <= w_new_start;
                                        r_ye <= w_new_end;
                                    end
                                end
                            endcase
                        end
                    end
                    S_RAMWR: begin
                        if (!r_have_hi) begin
                            r_hi      <= r_byte_q;
                            r_have_hi <= 1'b1;
                        end else begin
                            r_have_hi  <= 1'b0;
                            pix_valid  <= 1'b1;
                            pix_x      <= r_x;
                            pix_y      <= r_y;
                            pix_data   <= {r_hi, r_byte_q};
                            frame_done <= w_frame_fire;
                            if (r_x == r_xe) begin
                                r_x <= r_xs;
                                if (r_y == r_ye) begin
                                    r_y <= r_ys;
                                end else begin
                                    r_y <= r_y + c_one;
                                end
                            end else begin
                                r_x <= r_x + c_one;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef ILI_RX_STATS_EN
    // ------------------------------------------------------------------
    // Pixel / frame statistics, restarted by every RAMWR command.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_count   <= 32'd0;
            frame_count <= 16'd0;
        end else if (w_is_cmd && (r_byte_q == c_cmd_ramwr)) begin
            pix_count   <= 32'd0;
            frame_count <= 16'd0;
        end else begin
            if (w_pix_fire) begin
                pix_count <= pix_count + 32'd1;
            end
            if (w_frame_fire) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
